gpu_wb_master: RTL and testbench

Wishbone classic single-transfer initiator that drives the GPU's Wishbone slave port from an internal command source, such as a sequencer, a test harness or a management bridge. Host-side requests (read/write, address, data, byte select) are queued in a small FIFO and issued one at a time on the bus. Each completed transfer returns exactly one response pulse carrying read data. It is the initiator counterpart of the GPU register/matrix/command slave and sits directly on that slave's `wbs_*` port.

---
 rtl/gpu_wb_master.sv | 200 ++++++++++++++++++++
 tb/tb_gpu_wb_master.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_wb_master.sv
// Wishbone classic single-transfer initiator: queues host requests and issues them one at a time.
// Latency: request into empty FIFO -> cyc/stb next edge; ack at edge M -> rsp_valid_o pulse in cycle after M.
// Backpressure: req_ready_o drops when the request FIFO is full; responses are not backpressured.
// Optional bus watchdog: define GPU_WBM_TIMEOUT_EN to abort a transfer after TIMEOUT_CYCLES unacked BUS cycles.

module gpu_wb_master #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  // host request side
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [29:0] req_adr_i,
  input  logic [31:0] req_dat_i,
  input  logic [3:0]  req_sel_i,
  // host response side
  output logic        rsp_valid_o,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        busy_o,
  // Wishbone initiator port
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [29:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // One queued request, kept as a single packed word in the FIFO.
  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [29:0] adr;
    logic [31:0] dat;
  } wbm_req_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } state_t;

  // Illegal parameter combinations leave this marker block in the elaborated hierarchy.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
  end

  // ---------------------------------------------------------------------------
  // Request FIFO: pointers carry one extra wrap bit so full and empty differ.
  // ---------------------------------------------------------------------------
  wbm_req_t        fifo_mem [FIFO_DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic            fifo_empty;
  logic            fifo_full;
  logic            fifo_push;
  logic            fifo_pop;
  wbm_req_t        push_req;
  wbm_req_t        head_req;
  state_t          state;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Readiness depends only on occupancy; a pop in the same cycle does not open a slot early.
  assign req_ready_o = !fifo_full;
  assign fifo_push   = req_valid_i && !fifo_full;
  assign fifo_pop    = (state == ST_IDLE) && !fifo_empty;

  assign push_req.we  = req_we_i;
  assign push_req.sel = req_sel_i;
  assign push_req.adr = req_adr_i;
  assign push_req.dat = req_dat_i;

  assign head_req = fifo_mem[rd_ptr[AW-1:0]];

  // Storage is write-only from the host side; contents are meaningless once pointers reset.
  always_ff @(posedge wb_clk_i) begin
    if (fifo_push) begin
      fifo_mem[wr_ptr[AW-1:0]] <= push_req;
    end
  end

  // Tail and head pointers advance independently; simultaneous push and pop keep occupancy.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (fifo_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Bus FSM with registered Wishbone and response outputs.
  // ---------------------------------------------------------------------------
  logic        cyc_q;
  logic        we_q;
  logic [3:0]  sel_q;
  logic [29:0] adr_q;
  logic [31:0] dat_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_dat_q;

`ifdef GPU_WBM_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] to_cnt;
  logic        rsp_err_q;
`endif

  // IDLE pops one request and starts a cycle; BUS holds outputs until ack (or watchdog expiry).
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= ST_IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
`ifdef GPU_WBM_TIMEOUT_EN
      to_cnt      <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
`ifdef GPU_WBM_TIMEOUT_EN
      rsp_err_q   <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          // A stray ack while idle is simply not looked at.
          if (!fifo_empty) begin
            we_q  <= head_req.we;
            sel_q <= head_req.sel;
            adr_q <= head_req.adr;
            dat_q <= head_req.dat;
            cyc_q <= 1'b1;
            state <= ST_BUS;
`ifdef GPU_WBM_TIMEOUT_EN
            to_cnt <= '0;
`endif
          end
        end
        ST_BUS: begin
          if (wbm_ack_i) begin
            // Ack wins even on the cycle the watchdog would have fired.
            cyc_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_dat_q   <= we_q ? 32'h0 : wbm_dat_i;
            state       <= ST_IDLE;
          end
`ifdef GPU_WBM_TIMEOUT_EN
          else if (to_cnt == TO_LAST) begin
            // Counter hitting the limit means TIMEOUT_CYCLES unacked BUS cycles have elapsed.
            cyc_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_dat_q   <= 32'h0;
            rsp_err_q   <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            to_cnt <= to_cnt + 16'd1;
          end
`endif
        end
        default: begin
          state <= ST_IDLE;
          cyc_q <= 1'b0;
        end
      endcase
    end
  end

  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_we_o    = we_q;
  assign wbm_sel_o   = sel_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign busy_o      = !fifo_empty || (state == ST_BUS);

`ifdef GPU_WBM_TIMEOUT_EN
  assign rsp_err_o = rsp_err_q;
`else
  assign rsp_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_gpu_wb_master.sv
// Self-checking bench for gpu_wb_master: directed test-plan scenarios plus random traffic.
// Latency: compares every DUT output once per cycle on the falling edge.
// Backpressure: request acceptance and readiness are predicted from a queue-based model.

module tb_gpu_wb_master;

  localparam int DEPTH = 4;
  localparam int TO    = 8;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [29:0] adr;
    logic [31:0] dat;
  } req_t;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [29:0] req_adr_i;
  logic [31:0] req_dat_i;
  logic [3:0]  req_sel_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;
  logic        busy_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [29:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;

  gpu_wb_master #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we_i),
    .req_adr_i   (req_adr_i),
    .req_dat_i   (req_dat_i),
    .req_sel_i   (req_sel_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_dat_o   (rsp_dat_o),
    .rsp_err_o   (rsp_err_o),
    .busy_o      (busy_o),
    .wbm_cyc_o   (wbm_cyc_o),
    .wbm_stb_o   (wbm_stb_o),
    .wbm_we_o    (wbm_we_o),
    .wbm_sel_o   (wbm_sel_o),
    .wbm_adr_o   (wbm_adr_o),
    .wbm_dat_o   (wbm_dat_o),
    .wbm_ack_i   (wbm_ack_i),
    .wbm_dat_i   (wbm_dat_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference model: pending requests, the transfer on the bus (or the last one), and the expected response.
  req_t        m_fifo[$];
  req_t        m_bus;
  logic        m_inflight;
  int          m_age;
  logic        m_rsp_vld;
  logic [31:0] m_rsp_dat;
  logic        m_rsp_err;
  logic        m_accept;
  int          m_rsp_total;
  int          rsp_seen;

  task automatic model_reset();
    m_fifo.delete();
    m_bus      = '0;
    m_inflight = 1'b0;
    m_age      = 0;
    m_rsp_vld  = 1'b0;
    m_rsp_dat  = '0;
    m_rsp_err  = 1'b0;
  endtask

  // One clock cycle: check outputs, drive inputs, advance the model over the coming edge.
  task automatic step(input logic rst, input logic v, input req_t r,
                      input logic ack, input logic [31:0] rdat);
    check("req_ready", 72'(req_ready_o), 72'(m_fifo.size() < DEPTH));
    check("busy",      72'(busy_o),      72'((m_fifo.size() != 0) || m_inflight));
    check("cyc",       72'(wbm_cyc_o),   72'(m_inflight));
    check("stb",       72'(wbm_stb_o),   72'(m_inflight));
    check("bus_out",   72'({wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o}), 72'(m_bus));
    check("rsp_valid", 72'(rsp_valid_o), 72'(m_rsp_vld));
    if (m_rsp_vld)
      check("rsp_err_dat", 72'({rsp_err_o, rsp_dat_o}), 72'({m_rsp_err, m_rsp_dat}));
    if (rsp_valid_o) rsp_seen++;

    wb_rst_i    = rst;
    req_valid_i = v;
    req_we_i    = r.we;
    req_sel_i   = r.sel;
    req_adr_i   = r.adr;
    req_dat_i   = r.dat;
    wbm_ack_i   = ack;
    wbm_dat_i   = rdat;

    m_accept = 1'b0;
    if (rst) begin
      model_reset();
    end else begin
      m_rsp_vld = 1'b0;
      m_accept  = v && (m_fifo.size() < DEPTH);
      if (m_inflight) begin
        m_age++;
        if (ack) begin
          m_inflight  = 1'b0;
          m_rsp_vld   = 1'b1;
          m_rsp_err   = 1'b0;
          m_rsp_dat   = m_bus.we ? 32'h0 : rdat;
          m_rsp_total++;
        end
`ifdef GPU_WBM_TIMEOUT_EN
        else if (m_age == TO) begin
          m_inflight  = 1'b0;
          m_rsp_vld   = 1'b1;
          m_rsp_err   = 1'b1;
          m_rsp_dat   = 32'h0;
          m_rsp_total++;
        end
`endif
      end else if (m_fifo.size() != 0) begin
        m_bus      = m_fifo.pop_front();
        m_inflight = 1'b1;
        m_age      = 0;
      end
      if (m_accept) m_fifo.push_back(r);
    end
    @(negedge wb_clk_i);
  endtask

  function automatic req_t mk(input logic we, input logic [29:0] adr,
                              input logic [31:0] dat, input logic [3:0] sel);
    req_t r;
    r.we  = we;
    r.adr = adr;
    r.dat = dat;
    r.sel = sel;
    return r;
  endfunction

  function automatic req_t rnd_req();
    return mk(1'($urandom), 30'($urandom), $urandom, 4'($urandom));
  endfunction

  task automatic idle_steps(input int n, input logic ack);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, ack, $urandom);
  endtask

  initial begin
    req_t r;
    int   sent;
    int   guard;

    wb_rst_i    = 1'b1;
    req_valid_i = 1'b0;
    req_we_i    = 1'b0;
    req_adr_i   = '0;
    req_dat_i   = '0;
    req_sel_i   = '0;
    wbm_ack_i   = 1'b0;
    wbm_dat_i   = '0;
    m_rsp_total = 0;
    rsp_seen    = 0;
    model_reset();
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);

    // Write to adr 0 on a zero-wait slave.
    step(1'b0, 1'b1, mk(1'b1, 30'd0, 32'h1000_0000, 4'hF), 1'b1, $urandom);
    idle_steps(5, 1'b1);

    // Read adr 1 with 3 wait states.
    step(1'b0, 1'b1, mk(1'b0, 30'd1, 32'hDEAD_BEEF, 4'hF), 1'b0, $urandom);
    step(1'b0, 1'b0, '0, 1'b0, $urandom);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b0, $urandom);
    step(1'b0, 1'b0, '0, 1'b1, 32'h3000_2000);
    idle_steps(3, 1'b0);

    // Five back-to-back writes into a stalled slave, then drain.
    sent  = 0;
    guard = 0;
    while (sent < 5 && guard < 20) begin
      step(1'b0, 1'b1, mk(1'b1, 30'(sent), $urandom, 4'hF), 1'b0, $urandom);
      if (m_accept) sent++;
      guard++;
      if (guard == 8) step(1'b0, 1'b0, '0, 1'b1, $urandom);
    end
    check("five_writes_accepted", 72'(sent), 72'd5);
    idle_steps(16, 1'b1);

    // Reset while a transfer is on the bus with two more queued.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, rnd_req(), 1'b0, $urandom);
    step(1'b0, 1'b0, '0, 1'b0, $urandom);
    step(1'b1, 1'b0, '0, 1'b1, $urandom);
    idle_steps(2, 1'b0);
    step(1'b0, 1'b1, mk(1'b0, 30'h155, 32'h0, 4'h3), 1'b0, $urandom);
    step(1'b0, 1'b0, '0, 1'b0, $urandom);
    step(1'b0, 1'b0, '0, 1'b1, 32'hCAFE_F00D);
    idle_steps(3, 1'b1);

`ifdef GPU_WBM_TIMEOUT_EN
    // Slave never acks: first request times out, the second one issues after it.
    step(1'b0, 1'b1, rnd_req(), 1'b0, $urandom);
    step(1'b0, 1'b1, rnd_req(), 1'b0, $urandom);
    idle_steps(12, 1'b0);
    idle_steps(4, 1'b1);
`endif

    // Random traffic with random wait states, spurious acks and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      step(($urandom_range(0, 299) == 0), 1'($urandom), rnd_req(),
           ($urandom_range(0, 2) == 0), $urandom);
    end

    idle_steps(40, 1'b1);
    check("rsp_count", 72'(rsp_seen), 72'(m_rsp_total));
    check("drained_busy", 72'(busy_o), 72'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
